// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of a five-stage MIPS pipeline. Owns the program
// counter, drives the combinational instruction-memory address and registers
// the returned word into the IF/ID pipeline register.
//
// Parameters
//   RESET_PC     PC value loaded on reset (word aligned)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   imem_addr    fetch address (the PC register, never gated)
//   imem_instr   instruction word returned by memory in the same cycle
//   stall        hold PC, IF/ID and fetch_count
//   id_redirect  ID-stage control transfer taken; id_target is its target
//   ex_redirect  EX-stage control transfer (highest priority); ex_target
//   ifid_valid   IF/ID holds a real instruction
//   ifid_instr   registered instruction, 0 (NOP) when invalid
//   ifid_pc      address of ifid_instr
//   ifid_pc4     ifid_pc + 4 (link value)
//   fetch_count  number of valid instructions accepted into IF/ID
// -----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        id_redirect,
  input  logic [31:0] id_target,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] fetch_count
);

  // Low address bits are forced to zero everywhere a PC is loaded.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_ifid_pc;
  logic [31:0] r_ifid_pc4;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_ex_target;
  logic [31:0] w_id_target;

  // Mod 2^32 arithmetic: 0xFFFF_FFFC + 4 wraps to 0.
  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_ex_target = {ex_target[31:2], 2'b00};
  assign w_id_target = {id_target[31:2], 2'b00};

  // Priority: ex_redirect > stall > id_redirect > sequential fetch.
  // An id_redirect seen during a stall is dropped; the hazard unit keeps it
  // asserted until the stall clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC_ALIGNED;
      r_valid       <= 1'b0;
      r_instr       <= 32'h0;
      r_ifid_pc     <= 32'h0;
      r_ifid_pc4    <= 32'h0;
      r_fetch_count <= 32'h0;
    end else if (ex_redirect) begin
      r_pc       <= w_ex_target;
      r_valid    <= 1'b0;
      r_instr    <= 32'h0;
      r_ifid_pc  <= 32'h0;
      r_ifid_pc4 <= 32'h0;
    end else if (stall) begin
      r_pc          <= r_pc;
      r_valid       <= r_valid;
      r_instr       <= r_instr;
      r_ifid_pc     <= r_ifid_pc;
      r_ifid_pc4    <= r_ifid_pc4;
      r_fetch_count <= r_fetch_count;
    end else if (id_redirect) begin
      // The word fetched this cycle is the wrong-path slot: squash it.
      r_pc       <= w_id_target;
      r_valid    <= 1'b0;
      r_instr    <= 32'h0;
      r_ifid_pc  <= 32'h0;
      r_ifid_pc4 <= 32'h0;
    end else begin
      r_pc          <= w_pc_plus4;
      r_valid       <= 1'b1;
      r_instr       <= imem_instr;
      r_ifid_pc     <= r_pc;
      r_ifid_pc4    <= w_pc_plus4;
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign imem_addr   = r_pc;
  assign ifid_valid  = r_valid;
  assign ifid_instr  = r_instr;
  assign ifid_pc     = r_ifid_pc;
  assign ifid_pc4    = r_ifid_pc4;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage. Two instances share all stimulus: one with
// RESET_PC 0 and one with RESET_PC 0xFFFF_FFF8 (PC wrap). A behavioural model
// per instance tracks the expected PC / IF/ID / count and is compared on every
// falling edge; scripted scenarios add literal expectations, followed by a
// randomized phase with occasional reset pulses.
// -----------------------------------------------------------------------------
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        id_redirect;
  logic [31:0] id_target;
  logic        ex_redirect;
  logic [31:0] ex_target;

  logic [31:0] imem_addr   [2];
  logic [31:0] imem_instr  [2];
  logic        ifid_valid  [2];
  logic [31:0] ifid_instr  [2];
  logic [31:0] ifid_pc     [2];
  logic [31:0] ifid_pc4    [2];
  logic [31:0] fetch_count [2];

  int checks;
  int failures;
  bit cmp_en;

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h8c08_0000;
      32'h0000_0004: mem_word = 32'h0108_4820;
      32'h0000_0040: mem_word = 32'h2008_0063;
      32'h0000_0044: mem_word = 32'h2009_0007;
      default:       mem_word = {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h1357};
    endcase
  endfunction

  assign imem_instr[0] = mem_word(imem_addr[0]);
  assign imem_instr[1] = mem_word(imem_addr[1]);

  if_stage #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr[0]), .imem_instr(imem_instr[0]),
    .stall(stall), .id_redirect(id_redirect), .id_target(id_target),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .ifid_valid(ifid_valid[0]), .ifid_instr(ifid_instr[0]), .ifid_pc(ifid_pc[0]),
    .ifid_pc4(ifid_pc4[0]), .fetch_count(fetch_count[0])
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr[1]), .imem_instr(imem_instr[1]),
    .stall(stall), .id_redirect(id_redirect), .id_target(id_target),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .ifid_valid(ifid_valid[1]), .ifid_instr(ifid_instr[1]), .ifid_pc(ifid_pc[1]),
    .ifid_pc4(ifid_pc4[1]), .fetch_count(fetch_count[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] rst_pc [2];
  initial begin
    rst_pc[0] = 32'h0000_0000;
    rst_pc[1] = 32'hFFFF_FFF8;
  end

  logic [31:0] m_pc   [2];
  logic        m_v    [2];
  logic [31:0] m_ins  [2];
  logic [31:0] m_ipc  [2];
  logic [31:0] m_ipc4 [2];
  logic [31:0] m_cnt  [2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pc[k] <= rst_pc[k]; m_v[k] <= 1'b0; m_ins[k] <= 32'h0;
        m_ipc[k] <= 32'h0; m_ipc4[k] <= 32'h0; m_cnt[k] <= 32'h0;
      end else if (ex_redirect) begin
        m_pc[k] <= ex_target & ~32'h3;
        m_v[k] <= 1'b0; m_ins[k] <= 32'h0; m_ipc[k] <= 32'h0; m_ipc4[k] <= 32'h0;
      end else if (!stall) begin
        if (id_redirect) begin
          m_pc[k] <= id_target & ~32'h3;
          m_v[k] <= 1'b0; m_ins[k] <= 32'h0; m_ipc[k] <= 32'h0; m_ipc4[k] <= 32'h0;
        end else begin
          m_pc[k]   <= m_pc[k] + 32'd4;
          m_v[k]    <= 1'b1;
          m_ins[k]  <= mem_word(m_pc[k]);
          m_ipc[k]  <= m_pc[k];
          m_ipc4[k] <= m_pc[k] + 32'd4;
          m_cnt[k]  <= m_cnt[k] + 32'd1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("m%0d.imem_addr", k), imem_addr[k], m_pc[k]);
        check($sformatf("m%0d.valid", k), {31'h0, ifid_valid[k]}, {31'h0, m_v[k]});
        check($sformatf("m%0d.instr", k), ifid_instr[k], m_ins[k]);
        check($sformatf("m%0d.pc", k), ifid_pc[k], m_ipc[k]);
        check($sformatf("m%0d.pc4", k), ifid_pc4[k], m_ipc4[k]);
        check($sformatf("m%0d.count", k), fetch_count[k], m_cnt[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 1'b0; id_redirect = 1'b0; id_target = 32'h0;
    ex_redirect = 1'b0; ex_target = 32'h0;
  endtask

  initial begin
    int n;
    checks = 0; failures = 0; cmp_en = 1'b0;
    idle_inputs();
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    // Asynchronous reset values, before any clock edge.
    check("rst.addr0", imem_addr[0], 32'h0);
    check("rst.addr1", imem_addr[1], 32'hFFFF_FFF8);
    check("rst.valid0", {31'h0, ifid_valid[0]}, 32'h0);
    check("rst.instr0", ifid_instr[0], 32'h0);
    check("rst.count0", fetch_count[0], 32'h0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    cmp_en = 1'b1;

    // Sequential fetch from reset.
    tick();
    check("seq.pc0", ifid_pc[0], 32'h0);
    check("seq.instr0", ifid_instr[0], 32'h8c08_0000);
    check("seq.count0", fetch_count[0], 32'd1);
    check("wrap.pc_a", ifid_pc[1], 32'hFFFF_FFF8);
    tick();
    check("seq.pc1", ifid_pc[0], 32'h4);
    check("seq.instr1", ifid_instr[0], 32'h0108_4820);
    check("wrap.pc_b", ifid_pc[1], 32'hFFFF_FFFC);
    check("wrap.pc4_b", ifid_pc4[1], 32'h0);
    tick();
    check("wrap.pc_c", ifid_pc[1], 32'h0);
    check("seq.count3", fetch_count[0], 32'd3);
    for (int i = 0; i < 13; i++) tick();
    check("j.at3c", ifid_pc[0], 32'h3C);

    // j at 0x3C to 0x44: the word at 0x40 is squashed.
    id_redirect = 1'b1; id_target = 32'h44;
    tick();
    idle_inputs();
    check("j.squash_valid", {31'h0, ifid_valid[0]}, 32'h0);
    check("j.squash_count", fetch_count[0], 32'd16);
    check("j.addr", imem_addr[0], 32'h44);
    tick();
    check("j.tgt_pc", ifid_pc[0], 32'h44);
    check("j.tgt_instr", ifid_instr[0], 32'h2009_0007);
    check("j.tgt_count", fetch_count[0], 32'd17);

    // Stall 3 cycles with id_redirect held, then one unstalled cycle.
    stall = 1'b1; id_redirect = 1'b1; id_target = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall.pc", ifid_pc[0], 32'h44);
      check("stall.addr", imem_addr[0], 32'h48);
    end
    stall = 1'b0;
    tick();
    idle_inputs();
    check("stall.redir_addr", imem_addr[0], 32'h200);
    check("stall.redir_valid", {31'h0, ifid_valid[0]}, 32'h0);
    check("stall.redir_count", fetch_count[0], 32'd17);
    tick();

    // ex_redirect wins over stall and id_redirect; low bits dropped.
    stall = 1'b1; id_redirect = 1'b1; id_target = 32'h200;
    ex_redirect = 1'b1; ex_target = 32'h103;
    tick();
    idle_inputs();
    check("ex.addr", imem_addr[0], 32'h100);
    check("ex.valid", {31'h0, ifid_valid[0]}, 32'h0);
    tick();
    tick();

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst.addr1", imem_addr[1], 32'hFFFF_FFF8);
    check("arst.valid1", {31'h0, ifid_valid[1]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized phase.
    n = 0;
    repeat (3000) begin
      tick();
      stall       = ($urandom_range(0, 3) == 0);
      id_redirect = ($urandom_range(0, 4) == 0);
      ex_redirect = ($urandom_range(0, 9) == 0);
      id_target   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 1023);
      ex_target   = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 1023);
      rst         = ($urandom_range(0, 199) == 0);
      n++;
    end
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
